// File: rtl/router_src_arbiter.sv
// Round-robin arbiter sharing one router input port among NUM_SRC packet sources.
// Latency: grant registered one cycle after request; bytes forwarded combinationally from the grant.
// Backpressure: router busy gates src_ready; an idle or busy winner trips the watchdog abort.
//
// Ports:
//   clock, resetn      - system clock, synchronous active-low reset
//   src_req            - per-source request, held until its parity byte is accepted
//   src_pkt_valid      - per-source pkt_valid (low on the parity byte)
//   src_data           - per-source byte, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready          - byte-accept strobe back to the granted source
//   busy               - router busy; no byte accepted while high
//   pkt_valid, data_in - forwarded to the router input
//   grant              - registered one-hot grant (or zero)
//   err_abort          - one-cycle pulse when a grant is aborted
module router_src_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC-1:0]            src_pkt_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          busy,
  output logic                          pkt_valid,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          err_abort
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GD_W  = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] last_winner;
  logic             hdr_seen;
  logic [GD_W-1:0]  guard_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic                  in_xfer;
  logic                  win_req;
  logic                  win_pv;
  logic [DATA_WIDTH-1:0] win_dat;
  logic                  accept;
  logic                  wd_expired;
  logic                  abort;

  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_SRC-1:0]    pick_oh;
  logic [IDX_W:0]        cand;

  // Winner's byte lane, selected by the registered winner index.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == IDX_W'(i)) win_dat = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign in_xfer    = (state == XFER);
  assign win_req    = src_req[win_idx];
  assign win_pv     = src_pkt_valid[win_idx];
  assign accept     = in_xfer && !busy && win_req;
  assign wd_expired = (wd_cnt >= WD_W'(TIMEOUT - 1));
  // Withdrawal always aborts; the watchdog only fires on a cycle with no accepted byte,
  // so a source never sees src_ready for a byte that is then thrown away.
  assign abort      = in_xfer && (!win_req || (!accept && wd_expired));

  assign src_ready = accept ? grant : '0;
  assign pkt_valid = in_xfer && win_pv;
  assign data_in   = in_xfer ? win_dat : '0;

  // Round-robin pick: scan last_winner+1 .. last_winner+NUM_SRC (mod NUM_SRC).
  // The loop runs from lowest to highest priority so the last hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = {1'b0, last_winner} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) cand = cand - (IDX_W+1)'(NUM_SRC);
      if (src_req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = pick_vld;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      win_idx     <= '0;
      last_winner <= IDX_W'(NUM_SRC - 1);
      hdr_seen    <= 1'b0;
      guard_cnt   <= '0;
      wd_cnt      <= '0;
      err_abort   <= 1'b0;
    end else begin
      err_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick_oh;
            win_idx  <= pick_idx;
            hdr_seen <= 1'b0;
            wd_cnt   <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            err_abort   <= 1'b1;
            guard_cnt   <= '0;
            last_winner <= win_idx;
            state       <= GUARD;
          end else if (accept) begin
            wd_cnt <= '0;
            if (win_pv) begin
              hdr_seen <= 1'b1;
            end else if (hdr_seen) begin
              // Parity byte closes the packet.
              guard_cnt   <= '0;
              last_winner <= win_idx;
              state       <= GUARD;
            end
          end else if (wd_cnt < WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GUARD: begin
          if (guard_cnt < GD_W'(GUARD_CYCLES)) guard_cnt <= guard_cnt + 1'b1;
          // Hold the port while the router is still busy finishing the packet.
          if (guard_cnt >= GD_W'(GUARD_CYCLES - 1) && !busy) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/router_src_arbiter.md
Name: router_src_arbiter

Overview:
- Round-robin arbiter that shares the single router input port (pkt_valid, data_in, busy) among NUM_SRC packet sources.
- Grants one source at a time and holds the grant for one whole packet: header, payload, then the parity byte.
- Forwards the granted source onto the router input and back-pressures it with the router's busy.
- Releases the port after a guard interval, giving the router FSM time to return to address decode.
- Aborts a grant on source withdrawal or watchdog timeout.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..4).
- DATA_WIDTH, 8, byte width; header bits [1:0] = destination address.
- GUARD_CYCLES, 2, minimum cycles between end of packet and next grant.
- TIMEOUT, 64, maximum cycles allowed between accepted bytes within a packet.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- src_req  in  NUM_SRC  per-source request; held high until its packet's parity byte is accepted.
- src_pkt_valid  in  NUM_SRC  per-source pkt_valid; high for header and payload, low for the parity byte.
- src_data  in  NUM_SRC*DATA_WIDTH  per-source byte; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  out  NUM_SRC  byte-accept strobe to each source.
- busy  in  1  router busy; no byte is accepted while high.
- pkt_valid  out  1  to router.
- data_in  out  DATA_WIDTH  to router.
- grant  out  NUM_SRC  registered one-hot grant, or all-zero.
- err_abort  out  1  one-cycle pulse when a grant is aborted.

Behaviour:
- Reset (resetn low at an edge):
  - state=IDLE; grant=0; last_winner=NUM_SRC-1, so source 0 has first priority.
  - hdr_seen=0; guard_cnt=0; wd_cnt=0; err_abort=0.
  - Combinational outputs follow from the reset state: src_ready=0, pkt_valid=0, data_in=0.
  - Reset mid-packet drops the grant immediately; there is no partial-packet completion.
- Byte acceptance: a byte from winner w is accepted on an edge where state=XFER, busy=0 and src_req[w]=1.
  - src_ready[w] = that condition, combinational. All other src_ready bits are 0.
  - Sources advance to the next byte only after an edge with src_ready high.
- Forwarding, combinational from the registered grant:
  - In XFER: pkt_valid = src_pkt_valid[w]; data_in = src_data slice w.
  - Otherwise: pkt_valid=0; data_in=0.
- States:
  - IDLE:
    - If any src_req is high, select the first requester scanning upward from last_winner+1 modulo NUM_SRC.
    - Register grant (one-hot), clear hdr_seen and wd_cnt, go to XFER.
    - Grant is visible the cycle after the request is sampled.
  - XFER:
    - Accepted byte with src_pkt_valid[w]=1: set hdr_seen, wd_cnt=0.
    - Accepted byte with src_pkt_valid[w]=0 and hdr_seen=1: this is the parity byte. Go to GUARD, guard_cnt=0, last_winner=w.
    - Accepted byte with src_pkt_valid[w]=0 and hdr_seen=0: not forwarded as a packet (pkt_valid=0), no state change.
    - wd_cnt increments on every cycle without an accepted byte. This includes busy cycles, because busy beyond TIMEOUT is treated as a fault.
  - Abort, checked in XFER with priority over acceptance:
    - Triggered by src_req[w]=0, or by wd_cnt reaching TIMEOUT-1 without an accepted byte.
    - Pulse err_abort, go to GUARD, last_winner=w.
  - GUARD:
    - grant stays set but src_ready=0 and pkt_valid=0.
    - guard_cnt increments each cycle.
    - When guard_cnt >= GUARD_CYCLES-1 and busy=0: clear grant, go to IDLE.
- Fairness: a source just served has the lowest priority at the next arbitration.
  - A request rising in the same cycle the grant is released is arbitrated in IDLE on the following cycle; IDLE always lasts at least one cycle.
- Counter widths: $clog2(TIMEOUT+1) and $clog2(GUARD_CYCLES+1). Counters saturate and never wrap.
- Invariants: grant is always one-hot or zero; at most one src_ready bit is high.

Test Plan:
- Single packet, uncontended:
  - Stimulus: src 1 requests a header 8'h05 (addr 1, len 1), 1 payload byte, parity; busy=0.
  - Response: grant=3'b010 one cycle after the request; pkt_valid high for 2 cycles, then low with the parity byte on data_in; grant clears GUARD_CYCLES+1 cycles after parity is accepted.
- Round robin:
  - Stimulus: all three sources request continuously, 3 packets each.
  - Response: grant order 0,1,2,0,1,2,0,1,2; no err_abort.
- Busy back-pressure:
  - Stimulus: busy high for 5 cycles mid-payload.
  - Response: src_ready=0 throughout; data_in holds the same byte; no byte lost or duplicated; the packet completes normally.
- Watchdog:
  - Stimulus: busy held high for 64 cycles in XFER.
  - Response: err_abort pulses once exactly when wd_cnt=63; grant clears after the guard interval; the next source is served.
- Withdrawal:
  - Stimulus: src 2 drops src_req after the header is accepted.
  - Response: err_abort pulses the next edge; src 0 is granted after the guard interval.
- Reset mid-packet:
  - Stimulus: resetn low for 1 cycle during payload.
  - Response: next cycle grant=0, pkt_valid=0, src_ready=0; with all sources requesting, source 0 wins first.
